// File: rtl/branch_predictor.sv
// branch_predictor
//   Fetch-side branch direction predictor. A pattern history table (PHT) of
//   2-bit saturating counters answers a combinational taken/not-taken query for
//   the PC being fetched and learns from branch outcomes resolved in execute.
//   After reset an initialisation sweep writes weak-not-taken (01) to every
//   entry, one per cycle, before normal operation begins.
//
//   Optional feature: define BRANCH_PREDICTOR_GSHARE_EN to XOR a HIST_WIDTH-bit
//   global history register (updated at resolution) into the lookup index.
//
// Ports
//   clk            clock, all state updates on posedge
//   rst            asynchronous active-high reset
//   fetch_pc       PC of the instruction being fetched
//   predict_taken  prediction for fetch_pc (0 while initialising)
//   predict_index  PHT index used for this prediction, carried down the pipe
//   update_valid   a conditional branch resolved this cycle
//   update_index   predict_index that travelled with the resolved branch
//   update_taken   actual outcome of the resolved branch
//   init_busy      high while the initialisation sweep runs

module branch_predictor #(
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned HIST_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            fetch_pc,
  output logic                   predict_taken,
  output logic [INDEX_WIDTH-1:0] predict_index,
  input  logic                   update_valid,
  input  logic [INDEX_WIDTH-1:0] update_index,
  input  logic                   update_taken,
  output logic                   init_busy
);

  localparam int unsigned Depth = 2 ** INDEX_WIDTH;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;

  logic [1:0]             pht [Depth];
  logic                   pht_we;
  logic [INDEX_WIDTH-1:0] pht_waddr;
  logic [1:0]             pht_wdata;
  logic [1:0]             upd_ctr;

  logic [INDEX_WIDTH-1:0] base_index;
  logic [INDEX_WIDTH-1:0] hist_ext;

  // Word-aligned PC: bits [1:0] and anything above the index never matter.
  logic unused_pc;
  assign unused_pc  = ^{fetch_pc[31:INDEX_WIDTH+2], fetch_pc[1:0]};
  assign base_index = fetch_pc[INDEX_WIDTH+1:2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [HIST_WIDTH-1:0] ghr_q, ghr_d;

  always_comb begin
    hist_ext                 = '0;
    hist_ext[HIST_WIDTH-1:0] = ghr_q;
  end

  // History advances only on accepted updates, never speculatively.
  always_comb begin
    ghr_d = ghr_q;
    if (state_q == StRun && update_valid) begin
      ghr_d = {ghr_q[HIST_WIDTH-2:0], update_taken};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  logic [HIST_WIDTH-1:0] unused_hist;
  assign unused_hist = '0;
  assign hist_ext    = '0;
`endif

  assign predict_index = base_index ^ hist_ext;

  // Lookup reads the current table; a same-cycle write to the same entry is
  // only visible from the next cycle (no bypass).
  assign predict_taken = (state_q == StRun) ? pht[predict_index][1] : 1'b0;
  assign init_busy     = (state_q == StInit);

  // Saturating increment/decrement of the counter being updated.
  always_comb begin
    upd_ctr = pht[update_index];
    if (update_taken) begin
      if (upd_ctr != 2'b11) upd_ctr = upd_ctr + 2'b01;
    end else begin
      if (upd_ctr != 2'b00) upd_ctr = upd_ctr - 2'b01;
    end
  end

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    pht_we    = 1'b0;
    pht_waddr = update_index;
    pht_wdata = upd_ctr;
    unique case (state_q)
      StInit: begin
        pht_we    = 1'b1;
        pht_waddr = sweep_q;
        pht_wdata = 2'b01;
        sweep_d   = sweep_q + 1'b1;
        if (&sweep_q) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (update_valid) begin
          pht_we = 1'b1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Table has no reset; the sweep rewrites it. A write coinciding with reset
  // is dropped so no in-flight update survives.
  always_ff @(posedge clk) begin
    if (pht_we && !rst) begin
      pht[pht_waddr] <= pht_wdata;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic [5:0]  predict_index;
  logic        update_valid;
  logic [5:0]  update_index;
  logic        update_taken;
  logic        init_busy;

  int tests = 0;
  int fails = 0;

  // Reference history (only influences lookups in the gshare build).
  logic [5:0] ghr_m;
  logic       pend_acc;
  logic       pend_taken;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  localparam logic [5:0] GhrIdxExp = 6'h03;
`else
  localparam logic [5:0] GhrIdxExp = 6'h00;
`endif

  branch_predictor #(
    .INDEX_WIDTH(6),
    .HIST_WIDTH (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_pc     (fetch_pc),
    .predict_taken(predict_taken),
    .predict_index(predict_index),
    .update_valid (update_valid),
    .update_index (update_index),
    .update_taken (update_taken),
    .init_busy    (init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pc_for(input logic [5:0] idx);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    return {24'b0, idx ^ ghr_m, 2'b00};
`else
    return {24'b0, idx, 2'b00};
`endif
  endfunction

  // One cycle: drive update and lookup at the negedge, settle, then caller checks.
  task automatic cyc(input logic uv, input logic [5:0] ui, input logic ut, input logic [5:0] look);
    @(negedge clk);
    if (pend_acc) ghr_m = {ghr_m[4:0], pend_taken};
    update_valid = uv;
    update_index = ui;
    update_taken = ut;
    fetch_pc     = pc_for(look);
    pend_acc     = uv && !init_busy;
    pend_taken   = ut;
    #1;
  endtask

  task automatic chk_pred(input string tag, input logic exp_taken, input logic [5:0] idx);
    chk({tag, "_taken"}, {31'b0, predict_taken}, {31'b0, exp_taken});
    chk({tag, "_index"}, {26'b0, predict_index}, {26'b0, idx});
  endtask

  // Called at the negedge where reset was released; counts busy cycles.
  task automatic count_init(input string tag, input logic hold);
    int n;
    int bad;
    n   = 1;
    bad = 0;
    update_valid = hold;
    update_index = 6'd3;
    update_taken = 1'b1;
    fetch_pc     = 32'h0;
    pend_acc     = 1'b0;
    #1;
    if (predict_taken !== 1'b0) bad++;
    while (n < 200) begin
      @(negedge clk);
      if (init_busy !== 1'b1) break;
      n++;
      if (predict_taken !== 1'b0) bad++;
    end
    update_valid = 1'b0;
    #1;
    chk({tag, "_busy_cycles"}, n, 64);
    chk({tag, "_taken_low"}, bad, 0);
  endtask

  initial begin
    rst          = 1'b1;
    fetch_pc     = 32'h14;
    update_valid = 1'b0;
    update_index = '0;
    update_taken = 1'b0;
    ghr_m        = '0;
    pend_acc     = 1'b0;
    pend_taken   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {31'b0, init_busy}, 1);
    chk("rst_taken", {31'b0, predict_taken}, 0);
    chk("rst_index", {26'b0, predict_index}, 5);

    // Sweep with updates to index 3 held throughout (must be ignored)
    @(negedge clk);
    rst = 1'b0;
    count_init("init", 1'b1);

    for (int i = 0; i < 64; i++) begin
      cyc(1'b0, 6'd0, 1'b0, 6'(i));
      chk_pred("sweep_read", 1'b0, 6'(i));
    end

    // Index 3 still weak-NT: one taken moves it to weak-T
    cyc(1'b1, 6'd3, 1'b1, 6'd3);
    chk_pred("idx3_after_init", 1'b0, 6'd3);
    cyc(1'b0, 6'd0, 1'b0, 6'd3);
    chk_pred("idx3_one_taken", 1'b1, 6'd3);

    // Index 5: taken x3 then not-taken x4
    cyc(1'b1, 6'd5, 1'b1, 6'd5);
    chk_pred("t2_old01", 1'b0, 6'd5);
    cyc(1'b1, 6'd5, 1'b1, 6'd5);
    chk_pred("t2_10", 1'b1, 6'd5);
    cyc(1'b1, 6'd5, 1'b1, 6'd5);
    chk_pred("t2_11", 1'b1, 6'd5);
    cyc(1'b1, 6'd5, 1'b0, 6'd5);
    chk_pred("t2_sat11", 1'b1, 6'd5);
    cyc(1'b1, 6'd5, 1'b0, 6'd5);
    chk_pred("t3_10", 1'b1, 6'd5);
    cyc(1'b1, 6'd5, 1'b0, 6'd5);
    chk_pred("t3_01", 1'b0, 6'd5);
    cyc(1'b1, 6'd5, 1'b0, 6'd5);
    chk_pred("t3_00", 1'b0, 6'd5);
    cyc(1'b0, 6'd5, 1'b0, 6'd5);
    chk_pred("t3_sat00", 1'b0, 6'd5);
    cyc(1'b1, 6'd5, 1'b1, 6'd5);
    chk_pred("t3_from00", 1'b0, 6'd5);
    cyc(1'b0, 6'd5, 1'b0, 6'd5);
    chk_pred("t3_00to01", 1'b0, 6'd5);

    // Same-cycle lookup and update, no bypass
    cyc(1'b1, 6'd9, 1'b1, 6'd9);
    chk_pred("t5_same_cycle", 1'b0, 6'd9);
    cyc(1'b0, 6'd0, 1'b0, 6'd9);
    chk_pred("t5_next_cycle", 1'b1, 6'd9);

    // Other entries undisturbed
    cyc(1'b0, 6'd0, 1'b0, 6'd5);
    chk_pred("iso_idx5", 1'b0, 6'd5);
    cyc(1'b0, 6'd0, 1'b0, 6'd3);
    chk_pred("iso_idx3", 1'b1, 6'd3);

    // Reset from RUN, then again mid-sweep
    @(negedge clk);
    rst          = 1'b1;
    update_valid = 1'b0;
    pend_acc     = 1'b0;
    ghr_m        = '0;
    #1;
    chk("run_rst_busy", {31'b0, init_busy}, 1);
    chk("run_rst_taken", {31'b0, predict_taken}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("mid_sweep_busy", {31'b0, init_busy}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_init("reinit", 1'b0);

    cyc(1'b0, 6'd0, 1'b0, 6'd5);
    chk_pred("reinit_idx5", 1'b0, 6'd5);
    cyc(1'b0, 6'd0, 1'b0, 6'd3);
    chk_pred("reinit_idx3", 1'b0, 6'd3);

    // History: taken at index 0, then index 1
    cyc(1'b1, 6'd0, 1'b1, 6'd0);
    cyc(1'b1, 6'd1, 1'b1, 6'd1);
    cyc(1'b0, 6'd0, 1'b0, 6'd0);
    @(negedge clk);
    fetch_pc = 32'h0;
    #1;
    chk("ghr_index", {26'b0, predict_index}, {26'b0, GhrIdxExp});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
